div_iter_radix2: RTL and testbench

- Multi-cycle 32-bit radix-2 restoring divider for DIV/DIVU.
- Acts as the responder side of the execute-stage start/ready handshake.
- The ALU raises start_i with operands and a signedness flag, stalls the pipe, and consumes result_o when ready_o pulses.
- result_o is packed {remainder, quotient}, so HI = remainder and LO = quotient are written to hilo directly.

---
 rtl/div_pkg.sv | 18 +
 rtl/div_iter_radix2.sv | 170 +++++++++++++++++
 tb/tb_div_iter_radix2.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/div_pkg.sv
// Shared types and constants for the iterative radix-2 divider.
package div_pkg;

    localparam int unsigned DIV_WIDTH  = 32;
    localparam int unsigned DIV_CYCLES = 32;
    localparam int unsigned DIV_CNT_W  = 6;

    // Quotient returned for divide by zero
    localparam logic [DIV_WIDTH-1:0] DIV_DZ_QUO = '1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CALC  = 2'd1,
        DZERO = 2'd2,
        DONE  = 2'd3
    } div_state_t;

endpackage

// File: rtl/div_iter_radix2.sv
// Multi-cycle radix-2 restoring divider for DIV/DIVU; result packs {remainder, quotient}.
// One quotient bit per cycle; responds to a level start with a one-cycle ready pulse.
module div_iter_radix2
    import div_pkg::*;
#(
    parameter int unsigned WIDTH = DIV_WIDTH,
    parameter int unsigned CNT_W = DIV_CNT_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               flush,
    input  logic               annul_i,
    input  logic [WIDTH-1:0]   opdata1_i,
    input  logic [WIDTH-1:0]   opdata2_i,
    input  logic               start_i,
    input  logic               signed_div_i,
    output logic               ready_o,
    output logic [2*WIDTH-1:0] result_o,
    output logic               busy_o
);

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    div_state_t         r_state;
    logic [CNT_W-1:0]   r_cnt;
    logic [WIDTH-1:0]   r_rem;
    logic [WIDTH-1:0]   r_quo;
    logic [WIDTH-1:0]   r_dvs;
    logic [WIDTH-1:0]   r_dvd;
    logic               r_q_neg;
    logic               r_r_neg;
    logic               r_ready;
    logic               r_busy;
    logic [2*WIDTH-1:0] r_result;

    div_state_t         w_state_nxt;
    logic [CNT_W-1:0]   w_cnt_nxt;
    logic [WIDTH-1:0]   w_rem_nxt;
    logic [WIDTH-1:0]   w_quo_nxt;
    logic [WIDTH-1:0]   w_dvs_nxt;
    logic [WIDTH-1:0]   w_dvd_nxt;
    logic               w_q_neg_nxt;
    logic               w_r_neg_nxt;
    logic               w_ready_nxt;
    logic [2*WIDTH-1:0] w_result_nxt;

    logic               w_kill;
    logic               w_dvd_sgn;
    logic               w_dvs_sgn;
    logic [WIDTH-1:0]   w_dvd_mag;
    logic [WIDTH-1:0]   w_dvs_mag;
    logic [WIDTH:0]     w_shifted;
    logic [WIDTH:0]     w_trial;
    logic [WIDTH-1:0]   w_step_rem;
    logic [WIDTH-1:0]   w_step_quo;
    logic [WIDTH-1:0]   w_fin_rem;
    logic [WIDTH-1:0]   w_fin_quo;

    function automatic logic [WIDTH-1:0] neg_c(input logic [WIDTH-1:0] x);
        return ~x + WIDTH'(1);
    endfunction

    assign w_kill = flush | annul_i;

    // Signed mode divides magnitudes; |most-negative| wraps to itself, read as unsigned
    always_comb begin
        w_dvd_sgn = signed_div_i & opdata1_i[WIDTH-1];
        w_dvs_sgn = signed_div_i & opdata2_i[WIDTH-1];
        w_dvd_mag = w_dvd_sgn ? neg_c(opdata1_i) : opdata1_i;
        w_dvs_mag = w_dvs_sgn ? neg_c(opdata2_i) : opdata2_i;
    end

    // One restoring step: shift in the next dividend bit, trial-subtract the divisor
    always_comb begin
        w_shifted  = {r_rem, r_quo[WIDTH-1]};
        w_trial    = w_shifted - {1'b0, r_dvs};
        w_step_rem = w_trial[WIDTH] ? w_shifted[WIDTH-1:0] : w_trial[WIDTH-1:0];
        w_step_quo = {r_quo[WIDTH-2:0], ~w_trial[WIDTH]};
        w_fin_rem  = r_r_neg ? neg_c(w_step_rem) : w_step_rem;
        w_fin_quo  = r_q_neg ? neg_c(w_step_quo) : w_step_quo;
    end

    // Next-state and datapath update
    always_comb begin
        w_state_nxt  = r_state;
        w_cnt_nxt    = r_cnt;
        w_rem_nxt    = r_rem;
        w_quo_nxt    = r_quo;
        w_dvs_nxt    = r_dvs;
        w_dvd_nxt    = r_dvd;
        w_q_neg_nxt  = r_q_neg;
        w_r_neg_nxt  = r_r_neg;
        w_ready_nxt  = 1'b0;
        w_result_nxt = r_result;

        if (w_kill) begin
            w_state_nxt = IDLE;
        end else begin
            unique case (r_state)
                IDLE: begin
                    if (start_i) begin
                        w_cnt_nxt   = '0;
                        w_rem_nxt   = '0;
                        w_quo_nxt   = w_dvd_mag;
                        w_dvs_nxt   = w_dvs_mag;
                        w_dvd_nxt   = opdata1_i;
                        w_q_neg_nxt = w_dvd_sgn ^ w_dvs_sgn;
                        w_r_neg_nxt = w_dvd_sgn;
                        w_state_nxt = (opdata2_i == '0) ? DZERO : CALC;
                    end
                end
                CALC: begin
                    w_rem_nxt = w_step_rem;
                    w_quo_nxt = w_step_quo;
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                    if (r_cnt == LAST_CNT) begin
                        w_state_nxt  = DONE;
                        w_ready_nxt  = 1'b1;
                        w_result_nxt = {w_fin_rem, w_fin_quo};
                    end
                end
                DZERO: begin
                    // Deterministic divide-by-zero: raw dividend as remainder, no sign fix-up
                    w_state_nxt  = DONE;
                    w_ready_nxt  = 1'b1;
                    w_result_nxt = {r_dvd, WIDTH'(DIV_DZ_QUO)};
                end
                DONE: begin
                    w_state_nxt = IDLE;
                end
                default: begin
                    w_state_nxt = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state  <= IDLE;
            r_cnt    <= '0;
            r_rem    <= '0;
            r_quo    <= '0;
            r_dvs    <= '0;
            r_dvd    <= '0;
            r_q_neg  <= 1'b0;
            r_r_neg  <= 1'b0;
            r_ready  <= 1'b0;
            r_busy   <= 1'b0;
            r_result <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_cnt    <= w_cnt_nxt;
            r_rem    <= w_rem_nxt;
            r_quo    <= w_quo_nxt;
            r_dvs    <= w_dvs_nxt;
            r_dvd    <= w_dvd_nxt;
            r_q_neg  <= w_q_neg_nxt;
            r_r_neg  <= w_r_neg_nxt;
            r_ready  <= w_ready_nxt;
            r_busy   <= (w_state_nxt != IDLE);
            r_result <= w_result_nxt;
        end
    end

    assign ready_o  = r_ready;
    assign busy_o   = r_busy;
    assign result_o = r_result;

endmodule

// File: tb/tb_div_iter_radix2.sv
// Directed scoreboard bench for div_iter_radix2: latency, results, flush and async reset.
module tb_div_iter_radix2;

    logic        clk;
    logic        rst;
    logic        flush;
    logic        annul_i;
    logic [31:0] opdata1_i;
    logic [31:0] opdata2_i;
    logic        start_i;
    logic        signed_div_i;
    logic        ready_o;
    logic [63:0] result_o;
    logic        busy_o;

    typedef struct {
        logic [63:0] res;
        int          lat;
        string       tag;
    } exp_t;

    exp_t sb[$];
    int   n_assert;
    int   n_fail;

    div_iter_radix2 dut (
        .clk          (clk),
        .rst          (rst),
        .flush        (flush),
        .annul_i      (annul_i),
        .opdata1_i    (opdata1_i),
        .opdata2_i    (opdata2_i),
        .start_i      (start_i),
        .signed_div_i (signed_div_i),
        .ready_o      (ready_o),
        .result_o     (result_o),
        .busy_o       (busy_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input logic [63:0] obs, input logic [63:0] exp, input string tag);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] model(input logic [31:0] a, input logic [31:0] b,
                                          input logic sgn);
        logic signed [31:0] sa;
        logic signed [31:0] sb_;
        logic [31:0] q;
        logic [31:0] r;
        sa  = a;
        sb_ = b;
        if (sgn) begin
            q = 32'(sa / sb_);
            r = 32'(sa % sb_);
        end else begin
            q = a / b;
            r = a % b;
        end
        return {r, q};
    endfunction

    // Caller is at a negedge; start is driven in this cycle (cycle T)
    task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic sgn,
                          input logic [63:0] exp_r, input int exp_lat, input bit drop_early,
                          input string tag);
        exp_t e;
        int   lat;
        bit   got;
        e.res = exp_r;
        e.lat = exp_lat;
        e.tag = tag;
        sb.push_back(e);
        opdata1_i    = a;
        opdata2_i    = b;
        signed_div_i = sgn;
        start_i      = 1'b1;
        lat = 0;
        got = 1'b0;
        while (!got && lat < 60) begin
            @(negedge clk);
            lat++;
            if (lat == 1) begin
                opdata1_i = $urandom;
                opdata2_i = $urandom;
            end
            if (drop_early && lat == 2) start_i = 1'b0;
            if (ready_o === 1'b1) got = 1'b1;
        end
        start_i = 1'b0;
        chk(64'(got), 64'd1, {tag, " ready"});
        e = sb.pop_front();
        if (got) begin
            chk(64'(lat), 64'(e.lat), {e.tag, " latency"});
            chk(result_o, e.res, {e.tag, " result"});
            chk(64'(busy_o), 64'd1, {e.tag, " busy in done"});
        end
        // Following IDLE cycle: pulse gone, result held
        @(negedge clk);
        chk(64'(ready_o), 64'd0, {tag, " ready one cycle"});
        chk(result_o, e.res, {tag, " result held"});
    endtask

    initial begin
        logic [63:0] prev;
        logic [31:0] ra;
        logic [31:0] rb;
        logic        rs;
        n_assert     = 0;
        n_fail       = 0;
        rst          = 1'b0;
        flush        = 1'b0;
        annul_i      = 1'b0;
        opdata1_i    = '0;
        opdata2_i    = '0;
        start_i      = 1'b0;
        signed_div_i = 1'b0;
        repeat (3) @(negedge clk);
        chk(64'(ready_o), 64'd0, "reset ready");
        chk(64'(busy_o), 64'd0, "reset busy");
        chk(result_o, 64'd0, "reset result");
        rst = 1'b1;
        @(negedge clk);

        run_op(32'd100, 32'd7, 1'b0, {32'd2, 32'd14}, 33, 1'b0, "u100/7");
        run_op(32'hFFFFFFF9, 32'd2, 1'b1, {32'hFFFFFFFF, 32'hFFFFFFFD}, 33, 1'b0, "s-7/2");
        run_op(32'd7, 32'hFFFFFFFE, 1'b1, {32'h00000001, 32'hFFFFFFFD}, 33, 1'b1, "s7/-2");
        run_op(32'h80000000, 32'hFFFFFFFF, 1'b1, {32'h0, 32'h80000000}, 33, 1'b0, "s_ovf");
        run_op(32'hFFFFFFFF, 32'd1, 1'b0, {32'h0, 32'hFFFFFFFF}, 33, 1'b0, "uMAX/1");
        run_op(32'h12345678, 32'd0, 1'b0, {32'h12345678, 32'hFFFFFFFF}, 2, 1'b0, "udz");
        run_op(32'hFFFFFFFB, 32'd0, 1'b1, {32'hFFFFFFFB, 32'hFFFFFFFF}, 2, 1'b0, "sdz");

        for (int i = 0; i < 4; i++) begin
            ra = $urandom;
            rb = $urandom_range(1, 32'h0000FFFF);
            rs = 1'(i & 1);
            if (i == 3) rb = ~rb;
            run_op(ra, rb, rs, model(ra, rb, rs), 33, 1'b0, $sformatf("rand%0d", i));
        end

        // Flush at T+10 of a 100/7 run; restart 9/3 at T+12
        prev         = result_o;
        opdata1_i    = 32'd100;
        opdata2_i    = 32'd7;
        signed_div_i = 1'b0;
        start_i      = 1'b1;
        for (int c = 1; c <= 12; c++) begin
            @(negedge clk);
            if (c == 10) begin
                flush   = 1'b1;
                start_i = 1'b0;
            end
            if (c == 11) begin
                flush = 1'b0;
                chk(64'(busy_o), 64'd0, "flush busy");
            end
            if (c >= 10) chk(64'(ready_o), 64'd0, $sformatf("flush no ready c%0d", c));
        end
        chk(result_o, prev, "flush result kept");
        run_op(32'd9, 32'd3, 1'b0, {32'd0, 32'd3}, 33, 1'b0, "u9/3 after flush");

        // annul_i acts like flush
        opdata1_i = 32'd40;
        opdata2_i = 32'd0;
        start_i   = 1'b1;
        annul_i   = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
        annul_i = 1'b0;
        repeat (3) @(negedge clk);
        chk(64'(busy_o), 64'd0, "annul busy");
        chk(result_o, {32'd0, 32'd3}, "annul result kept");

        // Async reset between clock edges mid-CALC
        opdata1_i = 32'd1000;
        opdata2_i = 32'd3;
        start_i   = 1'b1;
        repeat (5) @(negedge clk);
        chk(64'(busy_o), 64'd1, "busy mid calc");
        @(posedge clk);
        #2 rst = 1'b0;
        #1;
        chk(64'(ready_o), 64'd0, "async rst ready");
        chk(64'(busy_o), 64'd0, "async rst busy");
        chk(result_o, 64'd0, "async rst result");
        start_i = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        run_op(32'd50, 32'd5, 1'b0, {32'd0, 32'd10}, 33, 1'b0, "u50/5 after reset");

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
